// File: rtl/per_meas_pkg.sv
// Shared types and constants for the period measurement sequencer.
package per_meas_pkg;

  localparam int unsigned PER_W_DEF = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  // All-ones value of a w-bit counter.
  function automatic int unsigned per_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned PER_MAX = per_max(PER_W_DEF);

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus delay flop; flags a rising edge of an async pin.
module edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async_in,
  output logic o_rise_c
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Synchronizer chain; s3 holds the previous synchronized level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise_c = r_s2 & ~r_s3;

endmodule

// File: rtl/period_meas_ctrl.sv
// Measures clocks between successive rising edges of an async input and
// strobes the saturated count out to the capture register.
module period_meas_ctrl
  import per_meas_pkg::*;
#(
  parameter int unsigned PER_W = PER_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_sig,
  output logic             o_capture,
  output logic [PER_W-1:0] o_period,
  output logic             o_ovf,
  output logic             o_meas_vld
);

  localparam logic [PER_W-1:0] CNT_MAX = PER_W'(per_max(PER_W));

  logic w_rise;

  state_t           r_state;
  logic [PER_W-1:0] r_cnt;
  logic [PER_W-1:0] r_period;
  logic             r_ovf;
  logic             r_capture;
  logic             r_meas_vld;

  state_t           w_state_nxt;
  logic [PER_W-1:0] w_cnt_nxt;
  logic [PER_W-1:0] w_period_nxt;
  logic             w_ovf_nxt;
  logic             w_capture_nxt;
  logic             w_meas_vld_nxt;

  edge_sync u_edge_sync (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_async_in (i_sig),
    .o_rise_c   (w_rise)
  );

  // State, counter and output registers; reset discards any partial count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_period   <= '0;
      r_ovf      <= 1'b0;
      r_capture  <= 1'b0;
      r_meas_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_period   <= w_period_nxt;
      r_ovf      <= w_ovf_nxt;
      r_capture  <= w_capture_nxt;
      r_meas_vld <= w_meas_vld_nxt;
    end
  end

  // Next-state and next-output logic; disable overrides any edge.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_period_nxt   = r_period;
    w_ovf_nxt      = r_ovf;
    w_capture_nxt  = 1'b0;
    w_meas_vld_nxt = r_meas_vld;

    if (!i_en) begin
      w_state_nxt    = IDLE;
      w_cnt_nxt      = '0;
      w_meas_vld_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt_nxt      = '0;
          w_meas_vld_nxt = 1'b0;
          w_state_nxt    = ARM;
        end
        ARM: begin
          if (w_rise) begin
            w_cnt_nxt   = PER_W'(1);
            w_state_nxt = MEAS;
          end
        end
        MEAS: begin
          if (w_rise) begin
            w_period_nxt   = r_cnt;
            w_ovf_nxt      = (r_cnt == CNT_MAX);
            w_capture_nxt  = 1'b1;
            w_meas_vld_nxt = 1'b1;
            w_cnt_nxt      = PER_W'(1);
          end else if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + PER_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign o_capture  = r_capture;
  assign o_period   = r_period;
  assign o_ovf      = r_ovf;
  assign o_meas_vld = r_meas_vld;

endmodule

// File: tb/tb_period_meas_ctrl.sv
// Directed self-checking bench for period_meas_ctrl.
module tb_period_meas_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sig;
  logic       capture;
  logic [8:0] period;
  logic       ovf;
  logic       meas_vld;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [8:0] q_per[$];
  logic       q_ovf[$];
  int         q_cyc[$];

  period_meas_ctrl #(.PER_W(9)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_sig      (sig),
    .o_capture  (capture),
    .o_period   (period),
    .o_ovf      (ovf),
    .o_meas_vld (meas_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every strobe, sampled away from the active edge.
  always @(negedge clk) begin
    if (capture === 1'b1) begin
      q_per.push_back(period);
      q_ovf.push_back(ovf);
      q_cyc.push_back(cyc);
    end
  end

  task automatic pulse_train(input int spacing, input int n);
    for (int k = 0; k < n; k++) begin
      sig = 1'b1;
      repeat (spacing / 2) @(negedge clk);
      sig = 1'b0;
      repeat (spacing - spacing / 2) @(negedge clk);
    end
  endtask

  task automatic restart();
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; sig = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (capture !== 1'b0) begin failures++; $display("FAIL rst_capture got=%b exp=0", capture); end
    checks++; if (period !== 9'h000) begin failures++; $display("FAIL rst_period got=0x%0h exp=0x000", period); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", ovf); end
    checks++; if (meas_vld !== 1'b0) begin failures++; $display("FAIL rst_meas_vld got=%b exp=0", meas_vld); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_square20();
    int base;
    base = q_per.size();
    restart();
    pulse_train(20, 4);
    repeat (5) @(negedge clk);
    checks++; if (q_per.size() - base !== 3) begin failures++; $display("FAIL sq20_count got=%0d exp=3", q_per.size() - base); end
    for (int i = base; i < q_per.size(); i++) begin
      checks++; if (q_per[i] !== 9'h014) begin failures++; $display("FAIL sq20_period idx=%0d got=0x%0h exp=0x014", i, q_per[i]); end
      checks++; if (q_ovf[i] !== 1'b0) begin failures++; $display("FAIL sq20_ovf idx=%0d got=%b exp=0", i, q_ovf[i]); end
      if (i > base) begin
        checks++; if (q_cyc[i] - q_cyc[i-1] !== 20) begin failures++; $display("FAIL sq20_spacing idx=%0d got=%0d exp=20", i, q_cyc[i] - q_cyc[i-1]); end
      end
    end
    checks++; if (meas_vld !== 1'b1) begin failures++; $display("FAIL sq20_meas_vld got=%b exp=1", meas_vld); end
  endtask

  task automatic test_long421();
    int base;
    base = q_per.size();
    restart();
    pulse_train(421, 3);
    repeat (100) @(negedge clk);
    checks++; if (q_per.size() - base !== 2) begin failures++; $display("FAIL l421_count got=%0d exp=2", q_per.size() - base); end
    for (int i = base; i < q_per.size(); i++) begin
      checks++; if (q_per[i] !== 9'h1A5) begin failures++; $display("FAIL l421_period idx=%0d got=0x%0h exp=0x1a5", i, q_per[i]); end
      checks++; if (q_ovf[i] !== 1'b0) begin failures++; $display("FAIL l421_ovf idx=%0d got=%b exp=0", i, q_ovf[i]); end
    end
    checks++; if (period !== 9'h1A5) begin failures++; $display("FAIL l421_hold got=0x%0h exp=0x1a5", period); end
    checks++; if (capture !== 1'b0) begin failures++; $display("FAIL l421_quiet got=%b exp=0", capture); end
  endtask

  task automatic test_toggle();
    int base;
    base = q_per.size();
    restart();
    pulse_train(2, 6);
    repeat (5) @(negedge clk);
    checks++; if (q_per.size() - base !== 5) begin failures++; $display("FAIL tog_count got=%0d exp=5", q_per.size() - base); end
    for (int i = base; i < q_per.size(); i++) begin
      checks++; if (q_per[i] !== 9'h002) begin failures++; $display("FAIL tog_period idx=%0d got=0x%0h exp=0x002", i, q_per[i]); end
      if (i > base) begin
        checks++; if (q_cyc[i] - q_cyc[i-1] !== 2) begin failures++; $display("FAIL tog_spacing idx=%0d got=%0d exp=2", i, q_cyc[i] - q_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_ovf();
    int base;
    logic [8:0] exp_p[3];
    logic       exp_o[3];
    exp_p[0] = 9'h1FF; exp_p[1] = 9'h1FF; exp_p[2] = 9'h064;
    exp_o[0] = 1'b1;   exp_o[1] = 1'b1;   exp_o[2] = 1'b0;
    base = q_per.size();
    restart();
    pulse_train(600, 2);
    pulse_train(100, 2);
    repeat (5) @(negedge clk);
    checks++; if (q_per.size() - base !== 3) begin failures++; $display("FAIL ovf_count got=%0d exp=3", q_per.size() - base); end
    for (int i = 0; i < 3; i++) begin
      if (base + i < q_per.size()) begin
        checks++; if (q_per[base+i] !== exp_p[i]) begin failures++; $display("FAIL ovf_period idx=%0d got=0x%0h exp=0x%0h", i, q_per[base+i], exp_p[i]); end
        checks++; if (q_ovf[base+i] !== exp_o[i]) begin failures++; $display("FAIL ovf_flag idx=%0d got=%b exp=%b", i, q_ovf[base+i], exp_o[i]); end
      end
    end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_final got=%b exp=0", ovf); end
  endtask

  task automatic test_en_drop();
    int base;
    base = q_per.size();
    restart();
    pulse_train(30, 2);
    repeat (10) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (meas_vld !== 1'b0) begin failures++; $display("FAIL endrop_meas_vld got=%b exp=0", meas_vld); end
    checks++; if (period !== 9'h01E) begin failures++; $display("FAIL endrop_hold got=0x%0h exp=0x01e", period); end
    pulse_train(40, 2);
    checks++; if (q_per.size() - base !== 1) begin failures++; $display("FAIL endrop_nocap got=%0d exp=1", q_per.size() - base); end
    en = 1'b1;
    repeat (3) @(negedge clk);
    pulse_train(25, 3);
    repeat (5) @(negedge clk);
    checks++; if (q_per.size() - base !== 3) begin failures++; $display("FAIL reen_count got=%0d exp=3", q_per.size() - base); end
    for (int i = base + 1; i < q_per.size(); i++) begin
      checks++; if (q_per[i] !== 9'h019) begin failures++; $display("FAIL reen_period idx=%0d got=0x%0h exp=0x019", i, q_per[i]); end
    end
    checks++; if (meas_vld !== 1'b1) begin failures++; $display("FAIL reen_meas_vld got=%b exp=1", meas_vld); end
  endtask

  task automatic test_rst_mid();
    int base;
    restart();
    pulse_train(30, 2);
    base = q_per.size();
    // Edge whose rise cycle coincides with the reset cycle.
    sig = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sig = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (capture !== 1'b0) begin failures++; $display("FAIL rstmid_capture got=%b exp=0", capture); end
    checks++; if (period !== 9'h000) begin failures++; $display("FAIL rstmid_period got=0x%0h exp=0x000", period); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rstmid_ovf got=%b exp=0", ovf); end
    checks++; if (meas_vld !== 1'b0) begin failures++; $display("FAIL rstmid_meas_vld got=%b exp=0", meas_vld); end
    checks++; if (q_per.size() !== base) begin failures++; $display("FAIL rstmid_nocap got=%0d exp=%0d", q_per.size(), base); end
    repeat (10) @(negedge clk);
    pulse_train(30, 2);
    repeat (5) @(negedge clk);
    checks++; if (q_per.size() - base !== 1) begin failures++; $display("FAIL rstmid_count got=%0d exp=1", q_per.size() - base); end
    if (q_per.size() > base) begin
      checks++; if (q_per[base] !== 9'h01E) begin failures++; $display("FAIL rstmid_period2 got=0x%0h exp=0x01e", q_per[base]); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sig = 1'b0;
    @(negedge clk);
    test_reset();
    test_square20();
    test_long421();
    test_toggle();
    test_ovf();
    test_en_drop();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
